// File: rtl/cadence_pkg.sv
// Shared constants, counter-width helper and cadence arithmetic for the pedal-cadence front end.
// The CAD_SMOOTH_EN build option in cadence_meas selects cad_smooth instead of the raw window count.
package cadence_pkg;

    localparam int CAD_W   = 5;
    localparam int CAD_MAX = 31;
    localparam logic [CAD_W-1:0] CAD_MAX_V = 5'(CAD_MAX);

    localparam int FILT_CYC_DEF  = 512;
    localparam int WIN_CYC_DEF   = 4194304;
    localparam int STALL_CYC_DEF = 16777216;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int FILT_W_DEF  = cnt_w(FILT_CYC_DEF);
    localparam int WIN_W_DEF   = cnt_w(WIN_CYC_DEF);
    localparam int STALL_W_DEF = cnt_w(STALL_CYC_DEF + 1);

    function automatic logic [CAD_W-1:0] cad_sat(input logic [CAD_W:0] v);
        return (v > {1'b0, CAD_MAX_V}) ? CAD_MAX_V : v[CAD_W-1:0];
    endfunction

    // Weighted 3:1 running average, rounded; 7 bits hold 3*31+31+2 without overflow.
    function automatic logic [CAD_W-1:0] cad_smooth(input logic [CAD_W-1:0] prev,
                                                    input logic [CAD_W-1:0] nw);
        logic [6:0] acc;
        acc = ({2'b00, prev} * 7'd3) + {2'b00, nw} + 7'd2;
        return acc[6:2];
    endfunction

endpackage

// File: rtl/cad_sync_filt.sv
// Two-flop synchronizer and debounce filter for the raw pedal-magnet input.
// filt follows the synchronized input only after it has differed for FILT_CYC consecutive cycles.
module cad_sync_filt
    import cadence_pkg::*;
#(
    parameter int FILT_CYC = FILT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    localparam int FW = cnt_w(FILT_CYC);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYC - 1);

    logic          sync1_q, sync1_d;
    logic          sync_q, sync_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;

    always_comb begin
        sync1_d    = raw;
        sync_d     = sync1_q;
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (sync_q != filt_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                filt_d = sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync_q     <= 1'b0;
            filt_q     <= 1'b0;
            filt_cnt_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync_q     <= sync_d;
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/cadence_meas.sv
// Pedal-cadence front end: filtered rising edges counted per window, plus a stall detector.
// Define CAD_SMOOTH_EN to low-pass the cadence output across windows instead of reporting raw counts.
module cadence_meas
    import cadence_pkg::*;
#(
    parameter int FILT_CYC  = FILT_CYC_DEF,
    parameter int WIN_CYC   = WIN_CYC_DEF,
    parameter int STALL_CYC = STALL_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cadence_raw,
    output logic [CAD_W-1:0] cadence,
    output logic             cadence_vld,
    output logic             not_pedaling
);

    localparam int WW = cnt_w(WIN_CYC);
    localparam int SW = cnt_w(STALL_CYC + 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WIN_CYC - 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_CYC);

    logic             cad_filt;
    logic             cad_filt_q, cad_filt_d;
    logic             rise;
    logic             win_end;
    logic [CAD_W:0]   edge_sum;
    logic [CAD_W-1:0] new_cad;

    logic [WW-1:0]    win_cnt_q, win_cnt_d;
    logic [CAD_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CAD_W-1:0] cadence_q, cadence_d;
    logic             cadence_vld_q, cadence_vld_d;
    logic [SW-1:0]    stall_cnt_q, stall_cnt_d;
    logic             not_pedaling_q, not_pedaling_d;

    cad_sync_filt #(
        .FILT_CYC(FILT_CYC)
    ) u_sync_filt (
        .clk (clk),
        .rst (rst),
        .raw (cadence_raw),
        .filt(cad_filt)
    );

    always_comb begin
        cad_filt_d = cad_filt;
        rise       = cad_filt & ~cad_filt_q;
        win_end    = (win_cnt_q == WIN_LAST);
        win_cnt_d  = win_end ? '0 : win_cnt_q + 1'b1;

        // A rise on the terminal cycle still belongs to the closing window.
        edge_sum   = {1'b0, edge_cnt_q} + {{CAD_W{1'b0}}, rise};
        new_cad    = cad_sat(edge_sum);
        edge_cnt_d = win_end ? '0 : new_cad;

        cadence_d     = cadence_q;
        cadence_vld_d = win_end;
        if (win_end) begin
`ifdef CAD_SMOOTH_EN
            cadence_d = cad_smooth(cadence_q, new_cad);
`else
            cadence_d = new_cad;
`endif
        end

        stall_cnt_d = stall_cnt_q;
        if (rise) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != STALL_MAX) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end

        // Rise has priority over a simultaneous stall threshold.
        not_pedaling_d = not_pedaling_q;
        if (rise) begin
            not_pedaling_d = 1'b0;
        end else if (stall_cnt_d == STALL_MAX) begin
            not_pedaling_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cad_filt_q     <= 1'b0;
            win_cnt_q      <= '0;
            edge_cnt_q     <= '0;
            cadence_q      <= '0;
            cadence_vld_q  <= 1'b0;
            stall_cnt_q    <= STALL_MAX;
            not_pedaling_q <= 1'b1;
        end else begin
            cad_filt_q     <= cad_filt_d;
            win_cnt_q      <= win_cnt_d;
            edge_cnt_q     <= edge_cnt_d;
            cadence_q      <= cadence_d;
            cadence_vld_q  <= cadence_vld_d;
            stall_cnt_q    <= stall_cnt_d;
            not_pedaling_q <= not_pedaling_d;
        end
    end

    assign cadence      = cadence_q;
    assign cadence_vld  = cadence_vld_q;
    assign not_pedaling = not_pedaling_q;

endmodule

// File: tb/tb_cadence_meas.sv
// Directed testbench for cadence_meas with FILT_CYC=4, WIN_CYC=256, STALL_CYC=1024.
module tb_cadence_meas;

    localparam int FILT  = 4;
    localparam int WIN   = 256;
    localparam int STALL = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cadence_raw = 1'b0;
    logic [4:0] cadence;
    logic       cadence_vld;
    logic       not_pedaling;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_rise_edge = 0;

    always #10 clk = ~clk;

    cadence_meas #(
        .FILT_CYC (FILT),
        .WIN_CYC  (WIN),
        .STALL_CYC(STALL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cadence_raw (cadence_raw),
        .cadence     (cadence),
        .cadence_vld (cadence_vld),
        .not_pedaling(not_pedaling)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        int first;
        first = -1;
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cadence_raw = (i % 2 == 1);
            tick();
            n_checks++;
            if (cadence !== 5'd0 || cadence_vld !== 1'b0 || not_pedaling !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_hold: cadence=%0d vld=%0b np=%0b, required 0/0/1",
                         cadence, cadence_vld, not_pedaling);
            end
        end
        cadence_raw = 1'b0;
        rst = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (cadence_vld === 1'b1) begin
                first = k;
                break;
            end
        end
        n_checks++;
        if (first !== WIN) begin
            n_fail++;
            $display("FAIL first_strobe: seen at cycle %0d, required %0d", first, WIN);
        end
        $display("test_reset: first strobe at cycle %0d", first);
    endtask

    task automatic test_glitch();
        int strobes;
        bit np_low;
        strobes = 0;
        np_low = 1'b0;
        for (int i = 0; i < 600; i++) begin
            cadence_raw = ((i % 40) < 3);
            tick();
            if (not_pedaling !== 1'b1) np_low = 1'b1;
            if (cadence_vld === 1'b1) begin
                strobes++;
                n_checks++;
                if (cadence !== 5'd0) begin
                    n_fail++;
                    $display("FAIL glitch_cadence: cadence=%0d, required 0", cadence);
                end
            end
        end
        cadence_raw = 1'b0;
        n_checks++;
        if (np_low || strobes < 2) begin
            n_fail++;
            $display("FAIL glitch_stall: np_dropped=%0b strobes=%0d, required 0 and >=2",
                     np_low, strobes);
        end
        $display("test_glitch: %0d strobes observed", strobes);
    endtask

    task automatic test_square();
        int strobe_idx;
        int last_strobe;
        bit np_high;
        strobe_idx = 0;
        last_strobe = -1;
        np_high = 1'b0;
        for (int i = 0; i < 800; i++) begin
            cadence_raw = ((i % 20) < 10);
            if (i % 20 == 0) last_rise_edge = cyc + 1 + 2 + FILT;
            tick();
            if (i == 5) begin
                n_checks++;
                if (not_pedaling !== 1'b1) begin
                    n_fail++;
                    $display("FAIL square_np_early: np=%0b at cycle 6, required 1", not_pedaling);
                end
            end
            if (i == 6) begin
                n_checks++;
                if (not_pedaling !== 1'b0) begin
                    n_fail++;
                    $display("FAIL square_np_fall: np=%0b at cycle 7, required 0", not_pedaling);
                end
            end
            if (i > 6 && not_pedaling !== 1'b0) np_high = 1'b1;
            if (cadence_vld === 1'b1) begin
                if (last_strobe >= 0) begin
                    n_checks++;
                    if (cyc - last_strobe !== WIN) begin
                        n_fail++;
                        $display("FAIL square_spacing: strobe gap %0d, required %0d",
                                 cyc - last_strobe, WIN);
                    end
                end
                if (strobe_idx >= 1) begin
                    n_checks++;
                    if (cadence !== 5'd12 && cadence !== 5'd13) begin
                        n_fail++;
                        $display("FAIL square_cadence: cadence=%0d, required 12 or 13", cadence);
                    end
                end
                $display("test_square: strobe %0d cadence=%0d", strobe_idx, cadence);
                strobe_idx++;
                last_strobe = cyc;
            end
        end
        cadence_raw = 1'b0;
        n_checks++;
        if (np_high || strobe_idx < 3) begin
            n_fail++;
            $display("FAIL square_np_hold: np_rose=%0b strobes=%0d, required 0 and >=3",
                     np_high, strobe_idx);
        end
    endtask

    task automatic test_stall();
        bit np_seen;
        bit zero_seen;
        np_seen = 1'b0;
        zero_seen = 1'b0;
        cadence_raw = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (!np_seen && not_pedaling === 1'b1) begin
                np_seen = 1'b1;
                n_checks++;
                if (cyc !== last_rise_edge + STALL) begin
                    n_fail++;
                    $display("FAIL stall_np_rise: at cycle %0d, required %0d",
                             cyc, last_rise_edge + STALL);
                end
                $display("test_stall: not_pedaling rose %0d cycles after last rise",
                         cyc - last_rise_edge);
            end
            if (!zero_seen && cadence_vld === 1'b1 && (cyc - (WIN - 1)) > last_rise_edge) begin
                zero_seen = 1'b1;
                n_checks++;
                if (cadence !== 5'd0) begin
                    n_fail++;
                    $display("FAIL stall_cadence: cadence=%0d, required 0", cadence);
                end
                $display("test_stall: empty-window strobe cadence=%0d", cadence);
            end
            if (np_seen && zero_seen) break;
        end
        n_checks++;
        if (!(np_seen && zero_seen)) begin
            n_fail++;
            $display("FAIL stall_timeout: np_seen=%0b zero_seen=%0b, required 1/1",
                     np_seen, zero_seen);
        end
    endtask

    task automatic test_saturation();
        int strobe_n;
        int checked;
        strobe_n = 0;
        checked = 0;
        for (int i = 0; i < 700; i++) begin
            cadence_raw = ((i % 8) < 4);
            tick();
            if (cadence_vld === 1'b1) begin
                strobe_n++;
                if (strobe_n >= 2) begin
                    checked++;
                    n_checks++;
                    if (cadence !== 5'd31) begin
                        n_fail++;
                        $display("FAIL sat_cadence: cadence=%0d, required 31", cadence);
                    end
                end
                $display("test_saturation: strobe %0d cadence=%0d", strobe_n, cadence);
            end
        end
        cadence_raw = 1'b0;
        n_checks++;
        if (checked < 1) begin
            n_fail++;
            $display("FAIL sat_strobes: %0d full-window strobes, required >=1", checked);
        end
    endtask

    task automatic test_mid_reset();
        int strobes;
        int i;
        int next;
        strobes = 0;
        i = 0;
        next = -1;
        while (strobes < 2 && i < 700) begin
            cadence_raw = ((i % 20) < 10);
            tick();
            i++;
            if (cadence_vld === 1'b1) strobes++;
        end
        for (int j = 0; j < 100; j++) begin
            cadence_raw = ((i % 20) < 10);
            tick();
            i++;
        end
        n_checks++;
        if (strobes !== 2 || not_pedaling !== 1'b0 || cadence === 5'd0) begin
            n_fail++;
            $display("FAIL midrst_pre: strobes=%0d np=%0b cadence=%0d, required 2/0/nonzero",
                     strobes, not_pedaling, cadence);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (cadence !== 5'd0 || cadence_vld !== 1'b0 || not_pedaling !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_async: cadence=%0d vld=%0b np=%0b, required 0/0/1",
                     cadence, cadence_vld, not_pedaling);
        end
        cadence_raw = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (cadence_vld === 1'b1) begin
                next = k;
                break;
            end
        end
        n_checks++;
        if (next !== WIN) begin
            n_fail++;
            $display("FAIL midrst_strobe: next strobe at cycle %0d, required %0d", next, WIN);
        end
        $display("test_mid_reset: strobe %0d cycles after release", next);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_glitch();
        test_square();
        test_stall();
        test_saturation();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
